// File: rtl/vdc_pkg.sv
// rtl/vdc_pkg.sv - shared types and constants for the VDC vertical timing generator
package vdc_pkg;

   // Vertical FSM: counting character rows, or counting total-adjust scanlines
   typedef enum logic {
      VST_ROWS,
      VST_ADJUST
   } vst_t;

   // Programmed vsync width 0 stands for a 16-line pulse
   localparam logic [4:0] VS_WIDTH_ZERO = 5'd16;

   // Interlace mode that steps scanlines by two and offsets odd fields by one
   localparam logic [1:0] IM_SYNC_VIDEO = 2'b11;

endpackage

// File: rtl/vdc_signals_v.sv
// rtl/vdc_signals_v.sv - vertical timing: line/row/frame counters, vdispen, vsync, field
module vdc_signals_v
   import vdc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] reg_ht,
   input  logic [7:0] reg_hp,
   input  logic [7:0] reg_vt,
   input  logic [4:0] reg_va,
   input  logic [7:0] reg_vd,
   input  logic [7:0] reg_vp,
   input  logic [1:0] reg_im,
   input  logic [4:0] reg_ctv,
   input  logic [3:0] reg_vw,
   input  logic [4:0] reg_vss,
   input  logic       endCol,
   input  logic [7:0] col,
   output logic       hSyncStart,
   output logic       newLine,
   output logic       newFrame,
   output logic [7:0] row,
   output logic [4:0] line,
   output logic       vdispen,
   output logic       vsync,
   output logic       field
);

   vst_t       state, state_n;
   logic [7:0] row_n;
   logic [4:0] line_n;
   logic [4:0] adj_cnt, adj_n;
   logic [4:0] vs_cnt, vs_n;
   logic       vdispen_n, field_n;
   logic       new_frame;
   logic       line_end;
   logic       sync_video;
   logic [4:0] step;
   logic [4:0] line_start;
   logic [4:0] next_start;

   assign line_end   = enable & endCol & (col == reg_ht);
   assign hSyncStart = ~reset & enable & endCol & (col == reg_hp);
   assign vsync      = |vs_cnt;
   assign sync_video = (reg_im == IM_SYNC_VIDEO);
   assign step       = sync_video ? 5'd2 : 5'd1;
   assign line_start = sync_video ? {4'd0, field} : 5'd0;

   // Next-state for the row/adjust FSM and every counter; all updates gated by line_end
   always_comb begin
      state_n    = state;
      row_n      = row;
      line_n     = line;
      adj_n      = adj_cnt;
      vs_n       = vs_cnt;
      vdispen_n  = vdispen;
      field_n    = field;
      new_frame  = 1'b0;
      next_start = line_start;
      if (line_end) begin
         case (state)
            VST_ROWS: begin
               // >= rather than == so a step-2 scan that jumps past the last line still wraps
               if (line >= reg_ctv) begin
                  if (row == reg_vt) begin
                     if (reg_va == 5'd0) begin
                        new_frame = 1'b1;
                     end else begin
                        state_n = VST_ADJUST;
                        adj_n   = 5'd0;
                        line_n  = line_start;
                     end
                  end else begin
                     row_n  = row + 8'd1;
                     line_n = line_start;
                  end
               end else begin
                  line_n = line + step;
               end
            end
            VST_ADJUST: begin
               adj_n = adj_cnt + 5'd1;
               if (adj_cnt == reg_va - 5'd1) begin
                  new_frame = 1'b1;
               end
            end
            default: state_n = VST_ROWS;
         endcase

         if (new_frame) begin
            state_n = VST_ROWS;
            row_n   = 8'd0;
            field_n = reg_im[0] ? ~field : 1'b0;
            line_n  = reg_vss + (sync_video ? {4'd0, field_n} : 5'd0);
         end
         next_start = sync_video ? {4'd0, field_n} : 5'd0;

         // Frame-start set is applied last so it overrides a clear on the same line
         if (row_n == reg_vd) begin
            vdispen_n = 1'b0;
         end
         if (new_frame) begin
            vdispen_n = (reg_vd != 8'd0);
         end

         // A running vsync pulse is never restarted; it just counts down
         if (vs_cnt != 5'd0) begin
            vs_n = vs_cnt - 5'd1;
         end else if (row_n == reg_vp && line_n == next_start) begin
            vs_n = (reg_vw == 4'd0) ? VS_WIDTH_ZERO : {1'b0, reg_vw};
         end
      end
   end

   // State register; newLine/newFrame are line_end delayed by one cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= VST_ROWS;
         row      <= 8'd0;
         line     <= 5'd0;
         adj_cnt  <= 5'd0;
         vs_cnt   <= 5'd0;
         vdispen  <= 1'b0;
         field    <= 1'b0;
         newLine  <= 1'b0;
         newFrame <= 1'b0;
      end else begin
         state    <= state_n;
         row      <= row_n;
         line     <= line_n;
         adj_cnt  <= adj_n;
         vs_cnt   <= vs_n;
         vdispen  <= vdispen_n;
         field    <= field_n;
         newLine  <= line_end;
         newFrame <= new_frame;
      end
   end

endmodule

// File: tb/tb_vdc_signals_v.sv
// tb/tb_vdc_signals_v.sv - scoreboard bench for the VDC vertical timing generator
module tb_vdc_signals_v;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [7:0] reg_ht, reg_hp, reg_vt, reg_vd, reg_vp;
   logic [4:0] reg_va, reg_ctv, reg_vss;
   logic [1:0] reg_im;
   logic [3:0] reg_vw;
   logic       endCol;
   logic [7:0] col;
   logic       hSyncStart, newLine, newFrame, vdispen, vsync, field;
   logic [7:0] row;
   logic [4:0] line;

   logic hrun;
   logic en;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      logic [7:0] row;
      logic [4:0] line;
      bit         chk_line;
      logic       vdispen;
      logic       vsync;
      logic       field;
      logic       nf;
   } exp_t;
   exp_t sb[$];

   vdc_signals_v dut (
      .clk(clk), .reset(reset), .enable(enable),
      .reg_ht(reg_ht), .reg_hp(reg_hp), .reg_vt(reg_vt), .reg_va(reg_va),
      .reg_vd(reg_vd), .reg_vp(reg_vp), .reg_im(reg_im), .reg_ctv(reg_ctv),
      .reg_vw(reg_vw), .reg_vss(reg_vss), .endCol(endCol), .col(col),
      .hSyncStart(hSyncStart), .newLine(newLine), .newFrame(newFrame),
      .row(row), .line(line), .vdispen(vdispen), .vsync(vsync), .field(field)
   );

   always #5 clk = ~clk;

   // Horizontal stage stand-in: one column per enabled cycle, col 0..reg_ht
   initial begin
      col = 8'd0; endCol = 1'b0; enable = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (!hrun) col = reg_ht;
         else if (en) col = (col >= reg_ht) ? 8'd0 : col + 8'd1;
         endCol = hrun;
         enable = en;
      end
   end

   function automatic void push(input int r, input int l, input bit cl, input bit vd,
                                input bit vs, input bit f, input bit nf);
      exp_t e;
      e.row = r[7:0]; e.line = l[4:0]; e.chk_line = cl;
      e.vdispen = vd; e.vsync = vs; e.field = f; e.nf = nf;
      sb.push_back(e);
   endfunction

   task automatic set_regs(input int ht, input int hp, input int vt, input int va, input int vd,
                           input int vp, input int im, input int ctv, input int vw, input int vss);
      reg_ht = ht[7:0]; reg_hp = hp[7:0]; reg_vt = vt[7:0]; reg_va = va[4:0];
      reg_vd = vd[7:0]; reg_vp = vp[7:0]; reg_im = im[1:0]; reg_ctv = ctv[4:0];
      reg_vw = vw[3:0]; reg_vss = vss[4:0];
   endtask

   task automatic do_reset(input bit run);
      @(negedge clk);
      reset = 1'b1; hrun = run; en = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic release_reset;
      reset = 1'b0; hrun = 1'b1;
   endtask

   task automatic wait_line(input string name, input int budget, output bit ok);
      int c = 0;
      do begin
         @(negedge clk); c++;
      end while (!newLine && c < budget);
      ok = newLine;
      if (!ok) begin
         checks++; errors++;
         $display("FAIL %s: no newLine within %0d cycles, required one", name, budget);
      end
   endtask

   task automatic wait_frame(input string name, input int budget, output bit ok);
      int c = 0;
      do begin
         @(negedge clk); c++;
      end while (!newFrame && c < budget);
      ok = newFrame;
      if (!ok) begin
         checks++; errors++;
         $display("FAIL %s: no newFrame within %0d cycles, required one", name, budget);
      end
   endtask

   // Precondition: sitting on a negedge where newLine is high
   task automatic check_lines(input string name, input int count);
      bit ok;
      exp_t e;
      for (int i = 0; i < count; i++) begin
         if (i > 0) begin
            wait_line(name, 300, ok);
            if (!ok) return;
         end
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s line %0d: scoreboard empty, required an entry", name, i);
            return;
         end
         e = sb.pop_front();
         if (row !== e.row || (e.chk_line && line !== e.line) || vdispen !== e.vdispen ||
             vsync !== e.vsync || field !== e.field || newFrame !== e.nf) begin
            errors++;
            $display("FAIL %s line %0d: got row=%0d line=%0d vdispen=%b vsync=%b field=%b newFrame=%b, required row=%0d line=%0d vdispen=%b vsync=%b field=%b newFrame=%b",
                     name, i, row, line, vdispen, vsync, field, newFrame,
                     e.row, e.line, e.vdispen, e.vsync, e.field, e.nf);
         end
      end
   endtask

   // Compares len lines, then requires the very next line to open a new frame
   task automatic check_frame(input string name, input int len);
      bit ok;
      check_lines(name, len);
      wait_line(name, 300, ok);
      if (ok) begin
         checks++;
         if (newFrame !== 1'b1 || row !== 8'd0) begin
            errors++;
            $display("FAIL %s frame_len: after %0d lines got newFrame=%b row=%0d, required newFrame=1 row=0",
                     name, len, newFrame, row);
         end
      end
   endtask

   task automatic test_reset;
      set_regs(15, 10, 32, 0, 25, 29, 0, 7, 0, 0);
      do_reset(1'b0);
      checks++;
      if (row !== 8'd0 || line !== 5'd0 || vdispen !== 1'b0 || vsync !== 1'b0 || field !== 1'b0 ||
          newLine !== 1'b0 || newFrame !== 1'b0 || hSyncStart !== 1'b0) begin
         errors++;
         $display("FAIL reset: got row=%0d line=%0d vdispen=%b vsync=%b field=%b newLine=%b newFrame=%b hSyncStart=%b, required all 0",
                  row, line, vdispen, vsync, field, newLine, newFrame, hSyncStart);
      end
   endtask

   task automatic test_ntsc;
      bit ok;
      set_regs(15, 10, 32, 0, 25, 29, 0, 7, 0, 0);
      do_reset(1'b0);
      release_reset();
      wait_frame("ntsc_first", 6000, ok);
      if (!ok) return;
      for (int r = 0; r <= 32; r++)
         for (int l = 0; l < 8; l++)
            push(r, l, 1'b1, r < 25, (r == 29 || r == 30), 1'b0, (r == 0 && l == 0));
      check_frame("ntsc", 264);
   endtask

   // Continues from the newFrame cycle left by test_ntsc: row 0, line 0
   task automatic test_enable_hold;
      bit ok;
      int bad = 0;
      en = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (newLine !== 1'b0 || newFrame !== 1'b0 || hSyncStart !== 1'b0 || row !== 8'd0 || line !== 5'd0)
            bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL enable_hold: got %0d cycles with state change or pulse, required 0", bad);
      end
      en = 1'b1;
      wait_line("enable_resume", 300, ok);
      if (ok) begin
         checks++;
         if (row !== 8'd0 || line !== 5'd1 || newFrame !== 1'b0) begin
            errors++;
            $display("FAIL enable_resume: got row=%0d line=%0d newFrame=%b, required row=0 line=1 newFrame=0",
                     row, line, newFrame);
         end
      end
   endtask

   task automatic test_reset_mid_vsync;
      int c = 0;
      while (vsync !== 1'b1 && c < 6000) begin
         @(negedge clk); c++;
      end
      checks++;
      if (vsync !== 1'b1 || row !== 8'd29) begin
         errors++;
         $display("FAIL vsync_start: got vsync=%b row=%0d, required vsync=1 row=29", vsync, row);
         return;
      end
      reset = 1'b1; en = 1'b0;
      @(negedge clk);
      checks++;
      if (vsync !== 1'b0 || row !== 8'd0 || line !== 5'd0 || vdispen !== 1'b0 || newLine !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_vsync: got vsync=%b row=%0d line=%0d vdispen=%b newLine=%b, required all 0",
                  vsync, row, line, vdispen, newLine);
      end
      en = 1'b1;
   endtask

   task automatic test_hsync;
      bit ok;
      int bad = 0;
      int pulses = 0;
      set_regs(126, 102, 32, 0, 25, 29, 0, 7, 0, 0);
      do_reset(1'b1);
      repeat (300) begin
         @(negedge clk);
         if (hSyncStart !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL hsync_in_reset: got %0d pulses, required 0", bad);
      end
      release_reset();
      wait_line("hsync", 300, ok);
      if (!ok) return;
      bad = 0;
      for (int i = 0; i < 4 * 127; i++) begin
         if (hSyncStart === 1'b1) pulses++;
         if (hSyncStart !== (col == 8'd102)) bad++;
         @(negedge clk);
      end
      checks++;
      if (pulses != 4) begin
         errors++;
         $display("FAIL hsync_count: got %0d pulses in 4 lines, required 4", pulses);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL hsync_position: got %0d cycles where pulse and col==102 disagree, required 0", bad);
      end
   endtask

   task automatic test_adjust;
      bit ok;
      set_regs(15, 10, 3, 5, 2, 2, 0, 3, 3, 0);
      do_reset(1'b0);
      release_reset();
      wait_frame("adjust_first", 1000, ok);
      if (!ok) return;
      for (int r = 0; r <= 3; r++)
         for (int l = 0; l < 4; l++)
            push(r, l, 1'b1, r < 2, (r == 2 && l < 3), 1'b0, (r == 0 && l == 0));
      for (int a = 0; a < 5; a++)
         push(3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_frame("adjust", 21);
   endtask

   task automatic test_smooth_scroll;
      bit ok;
      set_regs(15, 10, 2, 0, 3, 1, 0, 7, 2, 3);
      do_reset(1'b0);
      release_reset();
      wait_frame("scroll_first", 1000, ok);
      if (!ok) return;
      for (int l = 3; l < 8; l++)
         push(0, l, 1'b1, 1'b1, 1'b0, 1'b0, (l == 3));
      for (int r = 1; r <= 2; r++)
         for (int l = 0; l < 8; l++)
            push(r, l, 1'b1, 1'b1, (r == 1 && l < 2), 1'b0, 1'b0);
      check_frame("scroll", 21);
   endtask

   task automatic test_interlace;
      bit ok;
      set_regs(15, 10, 1, 0, 2, 9, 3, 7, 1, 0);
      do_reset(1'b0);
      release_reset();
      wait_frame("interlace_first", 1000, ok);
      if (!ok) return;
      for (int r = 0; r <= 1; r++)
         for (int l = 1; l < 8; l += 2)
            push(r, l, 1'b1, 1'b1, 1'b0, 1'b1, (r == 0 && l == 1));
      check_frame("interlace_f1", 8);
      for (int l = 0; l < 8; l += 2)
         push(0, l, 1'b1, 1'b1, 1'b0, 1'b0, (l == 0));
      check_lines("interlace_f0", 4);
      wait_frame("interlace_next", 1000, ok);
      if (ok) begin
         checks++;
         if (field !== 1'b1 || line !== 5'd1) begin
            errors++;
            $display("FAIL interlace_toggle: got field=%b line=%0d, required field=1 line=1", field, line);
         end
      end
   endtask

   task automatic test_vd_zero;
      bit ok;
      set_regs(15, 10, 2, 0, 0, 0, 0, 1, 1, 0);
      do_reset(1'b0);
      release_reset();
      wait_frame("vd0_first", 1000, ok);
      if (!ok) return;
      for (int f = 0; f < 2; f++)
         for (int r = 0; r <= 2; r++)
            for (int l = 0; l < 2; l++)
               push(r, l, 1'b1, 1'b0, (r == 0 && l == 0), 1'b0, (r == 0 && l == 0));
      check_frame("vd0_a", 6);
      check_frame("vd0_b", 6);
   endtask

   task automatic test_row_wrap;
      bit ok;
      set_regs(15, 10, 32, 0, 0, 200, 0, 0, 2, 0);
      do_reset(1'b0);
      release_reset();
      wait_frame("wrap_first", 1000, ok);
      if (!ok) return;
      for (int i = 0; i < 20; i++) begin
         wait_line("wrap_pre", 300, ok);
         if (!ok) return;
      end
      checks++;
      if (row !== 8'd20) begin
         errors++;
         $display("FAIL wrap_row20: got row=%0d, required 20", row);
         return;
      end
      reg_vt = 8'd10;
      for (int r = 21; r <= 255; r++)
         push(r, 0, 1'b1, 1'b0, (r == 200 || r == 201), 1'b0, 1'b0);
      for (int r = 0; r <= 10; r++)
         push(r, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_line("wrap", 300, ok);
      if (!ok) return;
      check_frame("wrap", 246);
   endtask

   initial begin
      reset = 1'b1; hrun = 1'b0; en = 1'b1;
      set_regs(15, 10, 32, 0, 25, 29, 0, 7, 0, 0);
      test_reset();
      test_ntsc();
      test_enable_hold();
      test_reset_mid_vsync();
      test_hsync();
      test_adjust();
      test_smooth_scroll();
      test_interlace();
      test_vd_zero();
      test_row_wrap();
      sb.delete();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
